switch_ingress_queue: RTL and testbench

- Per-input ingress buffer directly upstream of the crossbar switch; one instance per switch input port.
- Accepts payload plus destination from a source with valid/ready and stores them in a DEPTH-entry FIFO.
- Presents the head entry to the switch input as one packed word: payload in the high bits, destination in the low bits.
- Holds the head across cycles in which the switch withholds ready; out-of-range destinations are filtered before they reach the switch.

---
 rtl/switch_ingress_queue.sv | 114 +++++++++++
 tb/tb_switch_ingress_queue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_ingress_queue.sv
// Per-input ingress FIFO feeding one crossbar input; filters out-of-range destinations.
// Optional head-of-line stall counter enabled by defining SWITCH_INGRESS_STALL_CNT_EN.
module switch_ingress_queue #(
    parameter int DATA_WIDTH = 64,
    parameter int OUTPUT_QTY = 8,
    parameter int DEPTH      = 4,
    localparam int DW        = $clog2(OUTPUT_QTY),
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_WIDTH-1:0]    s_data,
    input  logic [DW-1:0]            s_dest,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_WIDTH+DW-1:0] m_data,
    output logic [CW-1:0]            count,
    output logic                     drop
`ifdef SWITCH_INGRESS_STALL_CNT_EN
    ,
    output logic [15:0]              stall_cycles
`endif
);

    localparam int PW                = $clog2(DEPTH);
    localparam int EW                = DATA_WIDTH + DW;
    localparam logic [DW:0]   QTY    = (DW + 1)'(OUTPUT_QTY);
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          s_ready_q, s_ready_d;
    logic          m_valid_q, m_valid_d;
    logic          drop_q, drop_d;
    logic          accept, dest_ok, push, pop;

    // Ready/valid flags are derived from the next occupancy so both stay registered.
    always_comb begin
        accept   = s_valid && s_ready_q;
        dest_ok  = {1'b0, s_dest} < QTY;
        push     = accept && dest_ok;
        pop      = m_valid_q && m_ready;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        s_ready_d = (count_d != FULL);
        m_valid_d = (count_d != '0);
        drop_d    = accept && !dest_ok;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            drop_q    <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_data, s_dest};
        end
    end

    // Masking with m_valid keeps stale storage off the bus after reset.
    assign m_data  = m_valid_q ? mem_q[rd_ptr_q] : '0;
    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign count   = count_q;
    assign drop    = drop_q;

`ifdef SWITCH_INGRESS_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (pop) begin
            stall_d = '0;
        end else if (m_valid_q && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_switch_ingress_queue.sv
// Directed bench for switch_ingress_queue (OUTPUT_QTY=6 so destination filtering is reachable).
// A queue-based model is compared every cycle; literal checks pin the model at key points.
module tb_switch_ingress_queue;

    localparam int DATA_WIDTH = 64;
    localparam int OUTPUT_QTY = 6;
    localparam int DEPTH      = 4;
    localparam int DW         = 3;
    localparam int CW         = 3;

    logic                     clk;
    logic                     reset_n;
    logic                     s_valid;
    logic                     s_ready;
    logic [DATA_WIDTH-1:0]    s_data;
    logic [DW-1:0]            s_dest;
    logic                     m_valid;
    logic                     m_ready;
    logic [DATA_WIDTH+DW-1:0] m_data;
    logic [CW-1:0]            count;
    logic                     drop;
`ifdef SWITCH_INGRESS_STALL_CNT_EN
    logic [15:0]              stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    switch_ingress_queue #(
        .DATA_WIDTH(DATA_WIDTH),
        .OUTPUT_QTY(OUTPUT_QTY),
        .DEPTH     (DEPTH)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .s_dest (s_dest),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .count  (count),
        .drop   (drop)
`ifdef SWITCH_INGRESS_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Behavioural model: an ordered list of stored words.
    logic [DATA_WIDTH+DW-1:0] mq[$];
    logic                     e_drop  = 1'b0;
    logic [15:0]              e_stall = 16'd0;
    logic                     m_acc, m_pop, m_bad;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            e_drop  = 1'b0;
            e_stall = 16'd0;
        end else begin
            m_acc = s_valid && (mq.size() < DEPTH);
            m_bad = (int'(s_dest) >= OUTPUT_QTY);
            m_pop = (mq.size() != 0) && m_ready;
            if (m_pop) e_stall = 16'd0;
            else if ((mq.size() != 0) && (e_stall != 16'hFFFF)) e_stall = e_stall + 16'd1;
            if (m_pop) void'(mq.pop_front());
            if (m_acc && !m_bad) mq.push_back({s_data, s_dest});
            e_drop = m_acc && m_bad;
        end
    end

    always @(negedge clk) begin
        chk("cyc_s_ready", s_ready, (mq.size() < DEPTH));
        chk("cyc_m_valid", m_valid, (mq.size() != 0));
        chk("cyc_count", count, mq.size());
        chk("cyc_drop", drop, e_drop);
        if (mq.size() != 0) chk("cyc_m_data", m_data, mq[0]);
`ifdef SWITCH_INGRESS_STALL_CNT_EN
        chk("cyc_stall", stall_cycles, e_stall);
`endif
    end

    // Called at a negedge: apply inputs, return at the next negedge.
    task automatic cyc(input logic v, input logic [63:0] d, input logic [2:0] dst, input logic mr);
        s_valid = v;
        s_data  = d;
        s_dest  = dst;
        m_ready = mr;
        @(negedge clk);
    endtask

    int maxc;
    int pops;

    initial begin
        reset_n = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_dest  = '0;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_drop", drop, 0);
        chk("rst_m_data", m_data, 0);

        // single word
        cyc(1'b1, 64'hA5, 3'd3, 1'b1);
        chk("single_m_valid", m_valid, 1);
        chk("single_m_data", m_data, {64'hA5, 3'd3});
        chk("single_count", count, 1);
        cyc(1'b0, 64'h0, 3'd0, 1'b1);
        chk("single_drained", count, 0);
        chk("single_m_valid0", m_valid, 0);

        // fill to full, held-off fifth word, pop at full
        for (int i = 0; i < 4; i++) cyc(1'b1, 64'hD000 + 64'(i), 3'(i), 1'b0);
        chk("full_count", count, 4);
        chk("full_s_ready", s_ready, 0);
        chk("full_head", m_data, {64'hD000, 3'd0});
        cyc(1'b1, 64'hD004, 3'd4, 1'b0);
        cyc(1'b1, 64'hD004, 3'd4, 1'b0);
        chk("held_count", count, 4);
        chk("held_head", m_data, {64'hD000, 3'd0});
        cyc(1'b1, 64'hD004, 3'd4, 1'b1);
        chk("fullpop_count", count, 3);
        chk("fullpop_s_ready", s_ready, 1);
        chk("fullpop_head", m_data, {64'hD001, 3'd1});
        cyc(1'b1, 64'hD004, 3'd4, 1'b1);
        chk("pushpop_count", count, 3);
        chk("pushpop_head", m_data, {64'hD002, 3'd2});
        cyc(1'b0, 64'h0, 3'd0, 1'b1);
        chk("drain_d3", m_data, {64'hD003, 3'd3});
        cyc(1'b0, 64'h0, 3'd0, 1'b1);
        chk("drain_d4", m_data, {64'hD004, 3'd4});
        cyc(1'b0, 64'h0, 3'd0, 1'b1);
        chk("drain_empty", count, 0);

        // out-of-range destinations are dropped; the last legal one is kept
        cyc(1'b1, 64'hBAD, 3'd7, 1'b1);
        chk("drop7_pulse", drop, 1);
        chk("drop7_count", count, 0);
        chk("drop7_m_valid", m_valid, 0);
        cyc(1'b0, 64'h0, 3'd0, 1'b1);
        chk("drop_clear", drop, 0);
        cyc(1'b1, 64'hBAD6, 3'd6, 1'b1);
        chk("drop6_pulse", drop, 1);
        cyc(1'b1, 64'h55, 3'd5, 1'b1);
        chk("dest5_drop", drop, 0);
        chk("dest5_data", m_data, {64'h55, 3'd5});
        cyc(1'b0, 64'h0, 3'd0, 1'b1);
        chk("dest5_drained", count, 0);

        // streaming wrap-around
        maxc = 0;
        pops = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 64'h100 + 64'(i), 3'(i % 6), 1'b1);
            if (int'(count) > maxc) maxc = int'(count);
            chk("wrap_data", m_data, {64'h100 + 64'(i), 3'(i % 6)});
            if (m_valid) pops++;
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 64'h0, 3'd0, 1'b1);
            if (m_valid) pops++;
        end
        chk("wrap_max_le2", (maxc <= 2), 1);
        chk("wrap_pops", pops, 10);
        chk("wrap_empty", count, 0);

        // async reset with three stored words
        for (int i = 0; i < 3; i++) cyc(1'b1, 64'hE0 + 64'(i), 3'(i), 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 64'h0, 3'd0, 1'b0);
        chk("pre_rst_count", count, 3);
`ifdef SWITCH_INGRESS_STALL_CNT_EN
        chk("pre_rst_stall", stall_cycles, 5);
`endif
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_m_valid", m_valid, 0);
        chk("arst_s_ready", s_ready, 1);
        chk("arst_m_data", m_data, 0);
`ifdef SWITCH_INGRESS_STALL_CNT_EN
        chk("arst_stall", stall_cycles, 0);
`endif
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cyc(1'b1, 64'h77, 3'd2, 1'b1);
        chk("post_rst_data", m_data, {64'h77, 3'd2});
        chk("post_rst_count", count, 1);
        cyc(1'b0, 64'h0, 3'd0, 1'b1);
        chk("post_rst_empty", count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
